// File: rtl/mem_bus_master_pkg.sv
// Shared encodings for mem_bus_master: access sizes, FSM states, default watchdog limit.
package mem_bus_master_pkg;

  typedef enum logic [1:0] {
    SIZE_BYTE = 2'b00,
    SIZE_HALF = 2'b01,
    SIZE_WORD = 2'b10,
    SIZE_ILL  = 2'b11
  } size_e;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_RD     = 3'd1,
    ST_RMW_RD = 3'd2,
    ST_RMW_WR = 3'd3,
    ST_WR     = 3'd4,
    ST_DONE   = 3'd5
  } state_e;

  localparam int DEF_TIMEOUT_CYCLES = 64;

  function automatic logic is_misaligned(input size_e size, input logic [1:0] lsb);
    case (size)
      SIZE_HALF: return lsb[0];
      SIZE_WORD: return (lsb != 2'b00);
      default:   return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Little-endian lane handling: extracts/extends a load lane and merges a sub-word
// store lane into a fetched word (the driver has no byte enables).
module mem_lane_align
  import mem_bus_master_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  addr,
  input  size_e       size,
  input  logic        sign_ext,
  input  logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic [31:0] merge_data
);

  logic [7:0]  byte_s;
  logic [15:0] half_s;

  // Lane extraction with sign/zero extension.
  always_comb begin
    byte_s = word[7:0];
    case (addr)
      2'b00:   byte_s = word[7:0];
      2'b01:   byte_s = word[15:8];
      2'b10:   byte_s = word[23:16];
      default: byte_s = word[31:24];
    endcase
    half_s = addr[1] ? word[31:16] : word[15:0];
    case (size)
      SIZE_BYTE: load_data = {{24{sign_ext & byte_s[7]}}, byte_s};
      SIZE_HALF: load_data = {{16{sign_ext & half_s[15]}}, half_s};
      default:   load_data = word;
    endcase
  end

  // Store merge: only the addressed lane takes the new data.
  always_comb begin
    merge_data = word;
    case (size)
      SIZE_BYTE: begin
        case (addr)
          2'b00:   merge_data[7:0]   = wdata[7:0];
          2'b01:   merge_data[15:8]  = wdata[7:0];
          2'b10:   merge_data[23:16] = wdata[7:0];
          default: merge_data[31:24] = wdata[7:0];
        endcase
      end
      SIZE_HALF: begin
        if (addr[1]) begin
          merge_data[31:16] = wdata[15:0];
        end else begin
          merge_data[15:0] = wdata[15:0];
        end
      end
      default: merge_data = wdata;
    endcase
  end

endmodule

// File: rtl/mem_bus_master.sv
// MEM-stage load/store initiator for the SRAM driver's enable/ack interface.
// Optional ack watchdog enabled by defining MEM_TIMEOUT_EN.
module mem_bus_master
  import mem_bus_master_pkg::*;
#(
  parameter int ADDR_W         = 21,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  output logic              req_ready,
  output logic              busy,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic              mem_enable,
  output logic              mem_read_enable,
  output logic              mem_write_enable,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ack
);

  state_e            state_r, state_s;
  logic [ADDR_W-1:0] addr_r;
  logic [1:0]        lane_r;
  size_e             size_r;
  logic              sign_r;
  logic [31:0]       wdata_r;
  logic [31:0]       rdata_r;
  logic              err_r, valid_r, busy_r;
  logic              accept_s, bad_s, issuing_s, timeout_s;
  logic              set_resp_s, resp_err_s;
  logic [31:0]       resp_data_s, load_data_s, merge_data_s;
  size_e             req_size_s;

  assign req_size_s = size_e'(req_size);
  assign req_ready  = (state_r == ST_IDLE) && !rst;
  assign accept_s   = req_valid && req_ready;
  assign bad_s      = (req_size_s == SIZE_ILL) || is_misaligned(req_size_s, req_addr[1:0])
                   || ((req_addr >> (ADDR_W + 2)) != 32'd0);
  assign issuing_s  = state_r inside {ST_RD, ST_RMW_RD, ST_RMW_WR, ST_WR};

`ifdef MEM_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TMO_W-1:0] tmo_r;

  // Ack watchdog, restarted on every state change.
  always_ff @(posedge clk) begin
    if (rst) begin
      tmo_r <= '0;
    end else if (state_s != state_r) begin
      tmo_r <= '0;
    end else if (issuing_s && !mem_ack) begin
      tmo_r <= tmo_r + TMO_W'(1);
    end else begin
      tmo_r <= tmo_r;
    end
  end

  assign timeout_s = issuing_s && (tmo_r == TMO_W'(TIMEOUT_CYCLES));
`else
  logic unused_cfg_s;
  assign unused_cfg_s = (TIMEOUT_CYCLES != 32'sd0);
  assign timeout_s    = 1'b0;
`endif

  // Enable drops in the ack cycle so the driver never re-samples a stale request.
  assign mem_enable       = issuing_s && !mem_ack && !timeout_s;
  assign mem_read_enable  = state_r inside {ST_RD, ST_RMW_RD};
  assign mem_write_enable = state_r inside {ST_WR, ST_RMW_WR};
  assign mem_addr         = addr_r;
  assign mem_wdata        = wdata_r;
  assign busy             = busy_r;
  assign resp_valid       = valid_r;
  assign resp_rdata       = rdata_r;
  assign resp_err         = err_r;

  mem_lane_align u_lane (
    .word      (mem_rdata),
    .addr      (lane_r),
    .size      (size_r),
    .sign_ext  (sign_r),
    .wdata     (wdata_r),
    .load_data (load_data_s),
    .merge_data(merge_data_s)
  );

  // Next-state and response selection.
  always_comb begin
    state_s     = state_r;
    set_resp_s  = 1'b0;
    resp_err_s  = 1'b0;
    resp_data_s = 32'd0;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          if (bad_s) begin
            state_s    = ST_DONE;
            set_resp_s = 1'b1;
            resp_err_s = 1'b1;
          end else if (!req_we) begin
            state_s = ST_RD;
          end else if (req_size_s == SIZE_WORD) begin
            state_s = ST_WR;
          end else begin
            state_s = ST_RMW_RD;
          end
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_RD: begin
        if (mem_ack) begin
          state_s     = ST_DONE;
          set_resp_s  = 1'b1;
          resp_data_s = load_data_s;
        end else if (timeout_s) begin
          state_s    = ST_DONE;
          set_resp_s = 1'b1;
          resp_err_s = 1'b1;
        end else begin
          state_s = ST_RD;
        end
      end
      ST_RMW_RD: begin
        if (mem_ack) begin
          state_s = ST_RMW_WR;
        end else if (timeout_s) begin
          state_s    = ST_DONE;
          set_resp_s = 1'b1;
          resp_err_s = 1'b1;
        end else begin
          state_s = ST_RMW_RD;
        end
      end
      ST_RMW_WR, ST_WR: begin
        if (mem_ack) begin
          state_s    = ST_DONE;
          set_resp_s = 1'b1;
        end else if (timeout_s) begin
          state_s    = ST_DONE;
          set_resp_s = 1'b1;
          resp_err_s = 1'b1;
        end else begin
          state_s = state_r;
        end
      end
      ST_DONE: state_s = ST_IDLE;
      default: state_s = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Request capture, merged-word update and registered response/stall outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_r  <= '0;
      lane_r  <= 2'b00;
      size_r  <= SIZE_BYTE;
      sign_r  <= 1'b0;
      wdata_r <= 32'd0;
      rdata_r <= 32'd0;
      err_r   <= 1'b0;
      valid_r <= 1'b0;
      busy_r  <= 1'b0;
    end else begin
      if (accept_s) begin
        addr_r  <= req_addr[ADDR_W+1:2];
        lane_r  <= req_addr[1:0];
        size_r  <= req_size_s;
        sign_r  <= req_signed;
        wdata_r <= req_wdata;
      end else if ((state_r == ST_RMW_RD) && mem_ack) begin
        wdata_r <= merge_data_s;
      end
      if (set_resp_s) begin
        rdata_r <= resp_data_s;
        err_r   <= resp_err_s;
      end
      valid_r <= (state_s == ST_DONE);
      busy_r  <= state_s inside {ST_RD, ST_RMW_RD, ST_RMW_WR, ST_WR};
    end
  end

endmodule
